fb_port_arbiter: RTL and testbench

FB_PORT_ARBITER -- requirements
Module: fb_port_arbiter

---
 rtl/fb_port_arbiter_pkg.sv | 18 +
 rtl/fb_write_queue.sv | 75 +++++++
 rtl/fb_port_arbiter.sv | 132 +++++++++++++
 tb/tb_fb_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_port_arbiter_pkg.sv
// rtl/fb_port_arbiter_pkg.sv - shared video package: decision encoding and default widths
package fb_port_arbiter_pkg;

   localparam int FB_AW = 16;
   localparam int FB_DW = 12;

   typedef enum logic [1:0] {
      DEC_IDLE     = 2'd0,
      DEC_READ     = 2'd1,
      DEC_WRITE    = 2'd2,
      DEC_FORCE_WR = 2'd3
   } decision_t;

   function automatic logic is_write(input decision_t d);
      return (d == DEC_WRITE) || (d == DEC_FORCE_WR);
   endfunction

endpackage

// File: rtl/fb_write_queue.sv
// rtl/fb_write_queue.sv - posted-write FIFO with parallel address compare
module fb_write_queue #(
   parameter int AW    = 16,
   parameter int DW    = 12,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [AW-1:0] push_addr,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [AW-1:0] head_addr,
   output logic [DW-1:0] head_data,
   output logic          full,
   output logic          empty,
   input  logic [AW-1:0] cmp_addr,
   output logic          cmp_hit
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0] addr_mem [DEPTH];
   logic [DW-1:0] data_mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [PW-1:0] offset;
   logic          do_push;
   logic          do_pop;

   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;
   assign head_addr = addr_mem[rd_ptr];
   assign head_data = data_mem[rd_ptr];

   // Entry storage needs no reset: validity comes from pointers and count.
   always_ff @(posedge clk) begin
      if (do_push) begin
         addr_mem[wr_ptr] <= push_addr;
         data_mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // An entry is live when its distance from the read pointer is below the occupancy.
   always_comb begin
      cmp_hit = 1'b0;
      offset  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offset = PW'(i) - rd_ptr;
         if (({1'b0, offset} < count) && (addr_mem[i] == cmp_addr)) cmp_hit = 1'b1;
      end
   end

endmodule

// File: rtl/fb_port_arbiter.sv
// rtl/fb_port_arbiter.sv - single-port framebuffer RAM arbiter for posted writes and scan-out reads
module fb_port_arbiter
   import fb_port_arbiter_pkg::*;
#(
   parameter int AW       = FB_AW,
   parameter int DW       = FB_DW,
   parameter int WQ_DEPTH = 4,
   parameter int MAX_WAIT = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_req,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   output logic          wr_ready,
   input  logic          rd_req,
   input  logic [AW-1:0] rd_addr,
   output logic          rd_ready,
   output logic          rd_valid,
   output logic [DW-1:0] rd_data,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          wr_drop
);

   localparam int WW = $clog2(MAX_WAIT);
   localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT - 1);

   decision_t     dec;
   logic [WW-1:0] wait_ctr;
   logic          q_full;
   logic          q_empty;
   logic          q_hit;
   logic [AW-1:0] head_addr;
   logic [DW-1:0] head_data;
   logic          push;
   logic          pop;
   logic          rd_pend;

   fb_write_queue #(
      .AW    (AW),
      .DW    (DW),
      .DEPTH (WQ_DEPTH)
   ) u_wq (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_addr (wr_addr),
      .push_data (wr_data),
      .pop       (pop),
      .head_addr (head_addr),
      .head_data (head_data),
      .full      (q_full),
      .empty     (q_empty),
      .cmp_addr  (rd_addr),
      .cmp_hit   (q_hit)
   );

   // Per-cycle port decision; a pending hazard or starved write outranks scan-out.
   always_comb begin
      dec = DEC_IDLE;
      if (reset) begin
         dec = DEC_IDLE;
      end else if (!q_empty && (q_full || (wait_ctr == WAIT_MAX) || q_hit)) begin
         dec = DEC_FORCE_WR;
      end else if (rd_req) begin
         dec = DEC_READ;
      end else if (!q_empty) begin
         dec = DEC_WRITE;
      end
   end

   assign wr_ready = !q_full;
   assign rd_ready = (dec == DEC_READ);
   assign push     = wr_req && !q_full;
   assign pop      = is_write(dec);
   assign rd_data  = mem_rdata;

   // Counts reads that overtook a waiting write, saturating at the force threshold.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_ctr <= '0;
      end else if (pop || q_empty) begin
         wait_ctr <= '0;
      end else if ((dec == DEC_READ) && (wait_ctr != WAIT_MAX)) begin
         wait_ctr <= wait_ctr + WW'(1);
      end
   end

   // Registered RAM command: this cycle's decision drives the RAM next cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_en <= (dec != DEC_IDLE);
         mem_we <= pop;
         if (dec == DEC_READ) begin
            mem_addr <= rd_addr;
         end else if (pop) begin
            mem_addr  <= head_addr;
            mem_wdata <= head_data;
         end
      end
   end

   // Read return pipe: command register stage, then RAM output stage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_pend  <= 1'b0;
         rd_valid <= 1'b0;
      end else begin
         rd_pend  <= (dec == DEC_READ);
         rd_valid <= rd_pend;
      end
   end

   // Sticky overflow flag for writes offered while the queue was full.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_drop <= 1'b0;
      end else if (wr_req && q_full) begin
         wr_drop <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb/tb_fb_port_arbiter.sv - scoreboard bench for fb_port_arbiter
module tb_fb_port_arbiter;

   localparam int DEPTH    = 4;
   localparam int MAX_WAIT = 8;
   localparam int D_IDLE   = 0;
   localparam int D_READ   = 1;
   localparam int D_WRITE  = 2;
   localparam int D_FORCE  = 3;

   typedef struct {
      int          cyc;
      logic        we;
      logic [15:0] addr;
      logic [11:0] data;
   } mexp_t;

   typedef struct {
      int          cyc;
      logic [11:0] data;
   } rexp_t;

   typedef struct {
      logic [15:0] addr;
      logic [11:0] data;
   } wq_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wr_req = 1'b0;
   logic [15:0] wr_addr = '0;
   logic [11:0] wr_data = '0;
   logic        wr_ready;
   logic        rd_req = 1'b0;
   logic [15:0] rd_addr = '0;
   logic        rd_ready;
   logic        rd_valid;
   logic [11:0] rd_data;
   logic        mem_en;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [11:0] mem_wdata;
   logic [11:0] mem_rdata = '0;
   logic        wr_drop;

   logic [11:0] ram     [0:65535];
   logic [11:0] ref_mem [0:65535];

   mexp_t exp_mem[$];
   rexp_t exp_rd[$];
   wq_t   wq[$];
   int    wait_cnt = 0;
   bit    drop_m = 0;
   int    cyc = 0;
   int    vectors = 0;
   int    miscompares = 0;

   logic  mon_exp;
   mexp_t mon_m;
   rexp_t mon_r;
   logic  rr;
   int    grants;

   fb_port_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .wr_req    (wr_req),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_ready  (wr_ready),
      .rd_req    (rd_req),
      .rd_addr   (rd_addr),
      .rd_ready  (rd_ready),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .wr_drop   (wr_drop)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   // Synchronous single-port RAM, read data one cycle after enable.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata <= ram[mem_addr];
      end
   end

   function automatic logic [11:0] init_val(input int a);
      logic [15:0] av;
      av = 16'(a);
      return av[11:0] ^ 12'h5A5;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compares RAM commands and read returns against cycle-tagged expectations.
   always @(negedge clk) begin
      if (!reset) begin
         mon_exp = (exp_mem.size() > 0) && (exp_mem[0].cyc == cyc);
         chk("mem_en", mem_en, mon_exp);
         if (mon_exp) begin
            mon_m = exp_mem.pop_front();
            if (mem_en) begin
               chk("mem_we", mem_we, mon_m.we);
               chk("mem_addr", mem_addr, mon_m.addr);
               if (mon_m.we) chk("mem_wdata", mem_wdata, mon_m.data);
            end
         end
         mon_exp = (exp_rd.size() > 0) && (exp_rd[0].cyc == cyc);
         chk("rd_valid", rd_valid, mon_exp);
         if (mon_exp) begin
            mon_r = exp_rd.pop_front();
            if (rd_valid) chk("rd_data", rd_data, mon_r.data);
         end
      end
   end

   // One clock of stimulus; reference model decides from the arbitration rules.
   task automatic step(input logic w, input logic [15:0] wa, input logic [11:0] wd,
                       input logic r, input logic [15:0] ra, output logic got_rr);
      int    n;
      bit    hit;
      int    dec;
      mexp_t me;
      rexp_t re;
      wq_t   e;
      @(negedge clk);
      #1;
      wr_req = w; wr_addr = wa; wr_data = wd; rd_req = r; rd_addr = ra;
      #1;
      n = wq.size();
      hit = 0;
      foreach (wq[i]) if (wq[i].addr == ra) hit = 1;
      if (n > 0 && (n == DEPTH || wait_cnt == MAX_WAIT - 1 || hit)) dec = D_FORCE;
      else if (r)    dec = D_READ;
      else if (n > 0) dec = D_WRITE;
      else           dec = D_IDLE;
      chk("wr_ready", wr_ready, n < DEPTH);
      chk("rd_ready", rd_ready, dec == D_READ);
      chk("wr_drop", wr_drop, drop_m);
      got_rr = rd_ready;
      if (dec == D_READ) begin
         me.cyc = cyc + 1; me.we = 1'b0; me.addr = ra; me.data = '0;
         exp_mem.push_back(me);
         re.cyc = cyc + 2; re.data = ref_mem[ra];
         exp_rd.push_back(re);
      end else if (dec != D_IDLE) begin
         e = wq.pop_front();
         ref_mem[e.addr] = e.data;
         me.cyc = cyc + 1; me.we = 1'b1; me.addr = e.addr; me.data = e.data;
         exp_mem.push_back(me);
      end
      if (dec == D_WRITE || dec == D_FORCE || n == 0) wait_cnt = 0;
      else if (dec == D_READ && wait_cnt < MAX_WAIT - 1) wait_cnt++;
      if (w && n == DEPTH) drop_m = 1;
      if (w && n < DEPTH) begin
         e.addr = wa; e.data = wd;
         wq.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      logic x;
      for (int k = 0; k < n; k++) step(1'b0, 16'h0, 12'h0, 1'b0, 16'hFFFF, x);
   endtask

   // Reset asserted just after a clock edge so in-flight work is discarded.
   task automatic do_reset(input int n);
      @(posedge clk);
      #1;
      reset = 1'b1; wr_req = 1'b1; rd_req = 1'b1; wr_addr = 16'h0; rd_addr = 16'h0;
      wq.delete(); exp_mem.delete(); exp_rd.delete();
      wait_cnt = 0; drop_m = 0;
      for (int k = 0; k < n; k++) begin
         #1;
         chk("rst_wr_ready", wr_ready, 1);
         chk("rst_rd_ready", rd_ready, 0);
         chk("rst_rd_valid", rd_valid, 0);
         chk("rst_mem_en", mem_en, 0);
         chk("rst_mem_we", mem_we, 0);
         chk("rst_mem_addr", mem_addr, 0);
         chk("rst_mem_wdata", mem_wdata, 0);
         chk("rst_wr_drop", wr_drop, 0);
         @(posedge clk);
         #1;
      end
      reset = 1'b0; wr_req = 1'b0; rd_req = 1'b0; rd_addr = 16'hFFFF;
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) begin
         ram[i] = init_val(i);
         ref_mem[i] = init_val(i);
      end
      do_reset(3);
      idle(2);

      // Reads only, addresses 0,1,2 back to back.
      for (int k = 0; k < 3; k++) step(1'b0, 16'h0, 12'h0, 1'b1, 16'(k), rr);
      idle(4);

      // Single posted write with no reads.
      step(1'b1, 16'h0100, 12'hABC, 1'b0, 16'hFFFF, rr);
      idle(4);
      chk("ram_0100", ram[16'h0100], 12'hABC);

      // One queued write starved by reads is forced after MAX_WAIT-1 grants.
      step(1'b1, 16'h0300, 12'h111, 1'b1, 16'h0010, rr);
      grants = 0;
      for (int k = 0; k < 20; k++) begin
         step(1'b0, 16'h0, 12'h0, 1'b1, 16'(16'h0011 + k), rr);
         if (!rr) break;
         grants++;
      end
      chk("reads_before_force", grants, 7);
      idle(4);

      // Read-after-write to the same address returns the new pixel.
      step(1'b1, 16'h0200, 12'h123, 1'b0, 16'hFFFF, rr);
      step(1'b0, 16'h0, 12'h0, 1'b1, 16'h0200, rr);
      chk("raw_hazard_holds_read", rr, 0);
      for (int k = 0; k < 3; k++) step(1'b0, 16'h0, 12'h0, 1'b1, 16'h0200, rr);
      idle(4);

      // Five back-to-back writes under constant reads: fifth is dropped.
      for (int k = 0; k < 5; k++)
         step(1'b1, 16'(16'h0400 + k), 12'(12'h700 + k), 1'b1, 16'(16'h0020 + k), rr);
      for (int k = 0; k < 40; k++) step(1'b0, 16'h0, 12'h0, 1'b1, 16'(16'h0030 + (k % 8)), rr);
      idle(6);
      chk("wr_drop_sticky", wr_drop, 1);
      for (int k = 0; k < 4; k++) chk("overflow_ram", ram[16'h0400 + k], 12'h700 + k);
      chk("dropped_not_written", ram[16'h0404], init_val(16'h0404));

      // Reset with three queued writes and two reads in flight.
      for (int k = 0; k < 3; k++)
         step(1'b1, 16'(16'h0500 + k), 12'(12'h5F0 + k), 1'b1, 16'(16'h0040 + k), rr);
      do_reset(2);
      idle(10);
      for (int k = 0; k < 3; k++) chk("reset_discarded_write", ram[16'h0500 + k], init_val(16'h0500 + k));

      // Randomized traffic over a small address window to provoke hazards.
      for (int k = 0; k < 3000; k++)
         step(1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 12'($urandom),
              1'($urandom_range(0, 99) < 70), 16'($urandom_range(0, 15)), rr);
      idle(20);
      chk("scoreboard_drained", exp_mem.size() + exp_rd.size() + wq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
